debounce_multi: RTL and testbench

//   Multi-channel switch/button debouncer, a parametrised successor to the single-channel debouncer.
//   - CHANNELS independent inputs, each debounced by its own settle counter.
//   - Adds per-channel rise/fall strobes and sticky event flags with a clear input.
//   - Sits between the board's raw button/switch pins and the control logic.
//

---
 rtl/debounce_multi.sv | 79 +++++++
 tb/tb_debounce_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel debouncer with per-channel settle counters, rise/fall strobes and sticky event flags.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchroniser on every input bit.
module debounce_multi #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned THRESHOLD  = 250000,
    parameter int unsigned CNT_W      = 18,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [CHANNELS-1:0] i_Signal,
    input  logic [CHANNELS-1:0] i_Clear,
    output logic [CHANNELS-1:0] o_Debounced,
    output logic [CHANNELS-1:0] o_Rise,
    output logic [CHANNELS-1:0] o_Fall,
    output logic [CHANNELS-1:0] o_Event,
    output logic                o_Any
);

    localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESHOLD);

    logic [CHANNELS-1:0] samp;
    logic [CHANNELS-1:0] change;
    logic [CNT_W-1:0]    cnt [CHANNELS];

`ifdef DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1 <= {CHANNELS{INIT_LEVEL}};
            sync2 <= {CHANNELS{INIT_LEVEL}};
        end else begin
            sync1 <= i_Signal;
            sync2 <= sync1;
        end
    end

    assign samp = sync2;
`else
    assign samp = i_Signal;
`endif

    // A channel flips on the sample that would push its counter past THRESHOLD.
    always_comb begin
        change = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            change[i] = (samp[i] != o_Debounced[i]) && (cnt[i] == THR_C);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
            o_Debounced <= {CHANNELS{INIT_LEVEL}};
            o_Rise      <= '0;
            o_Fall      <= '0;
            o_Event     <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (samp[i] == o_Debounced[i] || change[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            o_Debounced <= o_Debounced ^ change;
            o_Rise      <= change & samp;
            o_Fall      <= change & ~samp;
            o_Event     <= (o_Event & ~i_Clear) | change;
        end
    end

    assign o_Any = |o_Event;

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised and directed bench for debounce_multi against a sliding-window reference model.
// Honours DEBOUNCE_SYNC_EN the same way as the design (two extra cycles of input delay).
module tb_debounce_multi;

    localparam int unsigned CH   = 2;
    localparam int unsigned THR  = 4;
    localparam int unsigned CW   = 3;
    localparam logic        INIT = 1'b0;
`ifdef DEBOUNCE_SYNC_EN
    localparam int unsigned SYNC = 2;
`else
    localparam int unsigned SYNC = 0;
`endif
    localparam int unsigned LAT = THR + SYNC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] sig = '0;
    logic [CH-1:0] clr = '0;
    logic [CH-1:0] deb, rise, fall, evt;
    logic          any;

    debounce_multi #(
        .CHANNELS  (CH),
        .THRESHOLD (THR),
        .CNT_W     (CW),
        .INIT_LEVEL(INIT)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_Signal   (sig),
        .i_Clear    (clr),
        .o_Debounced(deb),
        .o_Rise     (rise),
        .o_Fall     (fall),
        .o_Event    (evt),
        .o_Any      (any)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: a channel flips when its last THR+1 samples all differ from its current level.
    logic [CH-1:0] m_deb, m_rise, m_fall, m_evt;
    logic [CH-1:0] m_p1, m_p2;
    logic [THR:0]  m_hist [CH];

    task automatic model_reset();
        m_deb  = {CH{INIT}};
        m_rise = '0;
        m_fall = '0;
        m_evt  = '0;
        m_p1   = {CH{INIT}};
        m_p2   = {CH{INIT}};
        for (int c = 0; c < CH; c++) m_hist[c] = {(THR+1){INIT}};
    endtask

    task automatic model_step(input logic [CH-1:0] in_sig, input logic [CH-1:0] in_clr);
        logic [CH-1:0] s;
        logic [CH-1:0] flip;
        logic [THR:0]  want;
        s = (SYNC != 0) ? m_p2 : in_sig;
        m_p2 = m_p1;
        m_p1 = in_sig;
        flip = '0;
        for (int c = 0; c < CH; c++) begin
            m_hist[c] = {m_hist[c][THR-1:0], s[c]};
            want = {(THR+1){~m_deb[c]}};
            flip[c] = (m_hist[c] == want);
        end
        m_rise = flip & ~m_deb;
        m_fall = flip & m_deb;
        m_deb  = m_deb ^ flip;
        m_evt  = (m_evt & ~in_clr) | flip;
    endtask

    task automatic step(input logic [CH-1:0] s_in, input logic [CH-1:0] c_in, input string tag);
        logic [5*CH:0] exp_v, got_v;
        sig = s_in;
        clr = c_in;
        model_step(s_in, c_in);
        @(posedge clk);
        #1;
        exp_v = {m_deb, m_rise, m_fall, m_evt, |m_evt};
        got_v = {deb, rise, fall, evt, any};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: {deb,rise,fall,evt,any} got %b required %b", tag, got_v, exp_v);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [5*CH:0] got_v;
        got_v = {deb, rise, fall, evt, any};
        n_vec++;
        if (got_v !== '0) begin
            n_err++;
            $display("FAIL %s: outputs got %b required all zero", tag, got_v);
        end
    endtask

    task automatic test_reset();
        model_reset();
        sig = '0;
        clr = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b00, 2'b00, "reset_idle");
    endtask

    task automatic test_hold_high();
        for (int unsigned i = 0; i <= LAT + 1; i++) begin
            step(2'b01, 2'b00, "hold_high");
            n_vec++;
            if (i < LAT && deb[0] !== 1'b0) begin
                n_err++;
                $display("FAIL hold_early: deb0 got %b required 0 at step %0d", deb[0], i);
            end else if (i == LAT && (deb[0] !== 1'b1 || rise[0] !== 1'b1)) begin
                n_err++;
                $display("FAIL hold_edge: deb0/rise0 got %b%b required 11", deb[0], rise[0]);
            end else if (i == LAT + 1 && (rise[0] !== 1'b0 || evt[0] !== 1'b1 || any !== 1'b1)) begin
                n_err++;
                $display("FAIL hold_after: rise0/evt0/any got %b%b%b required 011", rise[0], evt[0], any);
            end
        end
    endtask

    task automatic test_glitch();
        for (int unsigned i = 0; i <= LAT; i++) step(2'b00, 2'b00, "glitch_fall");
        for (int i = 0; i < 4; i++) step(2'b01, 2'b00, "glitch_pre");
        step(2'b00, 2'b00, "glitch_low");
        for (int unsigned i = 0; i <= LAT; i++) begin
            step(2'b01, 2'b00, "glitch_post");
            n_vec++;
            if (deb[0] !== (i == LAT)) begin
                n_err++;
                $display("FAIL glitch_deb: deb0 got %b required %b at step %0d", deb[0], (i == LAT), i);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int unsigned i = 0; i <= LAT; i++) step(2'b00, 2'b00, "sim_low");
        for (int unsigned i = 0; i <= LAT; i++) step(2'b11, 2'b00, "sim_rise");
        n_vec++;
        if (rise !== 2'b11) begin
            n_err++;
            $display("FAIL sim_rise_both: rise got %b required 11", rise);
        end
        for (int unsigned i = 0; i <= LAT; i++) step(2'b01, 2'b00, "sim_fall1");
        n_vec++;
        if (fall !== 2'b10 || rise !== 2'b00) begin
            n_err++;
            $display("FAIL sim_fall_ch1: fall/rise got %b/%b required 10/00", fall, rise);
        end
    endtask

    task automatic test_clear_priority();
        step(2'b01, 2'b11, "clr_all");
        for (int unsigned i = 0; i <= LAT; i++) begin
            step(2'b00, (i == LAT) ? 2'b01 : 2'b00, "clr_collide");
        end
        n_vec++;
        if (evt[0] !== 1'b1 || fall[0] !== 1'b1) begin
            n_err++;
            $display("FAIL clr_priority: evt0/fall0 got %b%b required 11", evt[0], fall[0]);
        end
        step(2'b00, 2'b01, "clr_lone");
        n_vec++;
        if (evt[0] !== 1'b0) begin
            n_err++;
            $display("FAIL clr_lone_evt: evt0 got %b required 0", evt[0]);
        end
    endtask

    task automatic test_reset_midcount();
        for (int i = 0; i < 3; i++) step(2'b01, 2'b00, "mid_pre");
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i <= LAT; i++) begin
            step(2'b01, 2'b00, "mid_fresh");
            n_vec++;
            if (deb[0] !== (i == LAT)) begin
                n_err++;
                $display("FAIL mid_fresh_deb: deb0 got %b required %b at step %0d", deb[0], (i == LAT), i);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] lvl;
        int            hold [CH];
        logic [CH-1:0] c;
        lvl = '0;
        for (int k = 0; k < CH; k++) hold[k] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < CH; k++) begin
                if (hold[k] == 0) begin
                    lvl[k]  = 1'($urandom_range(0, 1));
                    hold[k] = int'($urandom_range(1, 2 * (THR + 2)));
                end
                hold[k]--;
            end
            c = '0;
            for (int k = 0; k < CH; k++) c[k] = ($urandom_range(0, 7) == 0);
            step(lvl, c, "random");
        end
    endtask

    initial begin
        test_reset();
        test_hold_high();
        test_glitch();
        test_simultaneous();
        test_clear_priority();
        test_reset_midcount();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
